// File: rtl/shiftreg16to8.sv
// Word-to-byte serializer: 16-bit words in over valid/ready, two bytes out over valid/ready.
// A one-word pending buffer keeps a continuous word stream producing one byte per cycle.
module shiftreg16to8 #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk2,
    input  logic             NReset,
    input  logic [15:0]      word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    // state  | meaning
    // IDLE   | nothing in flight, pending buffer empty
    // FIRST  | first byte of hold_q presented on byte_out
    // SECOND | second byte of hold_q presented on byte_out
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wacc;
    logic bxfr;
    logic sel_low;

    always_ff @(posedge clk2 or negedge NReset) begin
        if (!NReset) begin
            state_q     <= IDLE;
            hold_q      <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wacc = word_valid & word_ready;
    assign bxfr = byte_valid & byte_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (wacc) begin
                    hold_d  = word_in;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (wacc) begin
                    pend_d      = word_in;
                    pend_full_d = 1'b1;
                end
                if (bxfr) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (bxfr) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (pend_full_q) begin
                        hold_d      = pend_q;
                        pend_full_d = 1'b0;
                        state_d     = FIRST;
                    end else if (wacc) begin
                        // Bypass the empty pending buffer to avoid a bubble.
                        hold_d  = word_in;
                        state_d = FIRST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wacc) begin
                    pend_d      = word_in;
                    pend_full_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                pend_full_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        word_ready = !pend_full_q;
        byte_valid = (state_q == FIRST) || (state_q == SECOND);
        busy       = (state_q != IDLE);
        words_sent = cnt_q;
        // IDLE keeps showing the last byte sent, i.e. the SECOND selection.
        sel_low    = (state_q == FIRST) ? LSB_FIRST : !LSB_FIRST;
        byte_out   = sel_low ? hold_q[7:0] : hold_q[15:8];
    end

endmodule

// File: tb/tb_shiftreg16to8.sv
// Directed bench for shiftreg16to8: one LSB-first instance for handshake/reset/round-trip
// scenarios and one MSB-first instance for byte order and counter wrap.
module tb_shiftreg16to8;

    logic        clk2;
    logic        NReset;

    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic [7:0]  words_sent;

    logic [15:0] m_word_in;
    logic        m_word_valid;
    logic        m_word_ready;
    logic [7:0]  m_byte_out;
    logic        m_byte_valid;
    logic        m_byte_ready;
    logic        m_busy;
    logic [7:0]  m_words_sent;

    int n_vec = 0;
    int n_err = 0;

    shiftreg16to8 #(.LSB_FIRST(1'b1), .CNT_W(8)) dut (
        .clk2(clk2), .NReset(NReset),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .words_sent(words_sent)
    );

    shiftreg16to8 #(.LSB_FIRST(1'b0), .CNT_W(8)) dut_msb (
        .clk2(clk2), .NReset(NReset),
        .word_in(m_word_in), .word_valid(m_word_valid), .word_ready(m_word_ready),
        .byte_out(m_byte_out), .byte_valid(m_byte_valid), .byte_ready(m_byte_ready),
        .busy(m_busy), .words_sent(m_words_sent)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic test_reset();
        NReset = 1'b0;
        #3;
        n_vec++; if (word_ready !== 1'b1) begin n_err++; $display("FAIL reset_word_ready got %b want 1", word_ready); end
        n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
        n_vec++; if (byte_out !== 8'h00) begin n_err++; $display("FAIL reset_byte_out got %h want 00", byte_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (words_sent !== 8'd0) begin n_err++; $display("FAIL reset_words_sent got %0d want 0", words_sent); end
        step();
        step();
        NReset = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        byte_ready = 1'b1;
        word_in    = 16'hA55A;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'h5A) begin n_err++; $display("FAIL single_b0 got v=%b %h want v=1 5a", byte_valid, byte_out); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
        step();
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'hA5) begin n_err++; $display("FAIL single_b1 got v=%b %h want v=1 a5", byte_valid, byte_out); end
        step();
        n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle got v=%b busy=%b want 0 0", byte_valid, busy); end
        n_vec++; if (words_sent !== 8'd1) begin n_err++; $display("FAIL single_count got %0d want 1", words_sent); end
    endtask

    task automatic test_backpressure();
        byte_ready = 1'b0;
        word_in    = 16'h1234;
        word_valid = 1'b1;
        step();
        word_in = 16'hBEEF;
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'h34) begin n_err++; $display("FAIL bp_stall0 got v=%b %h want v=1 34", byte_valid, byte_out); end
        step();
        word_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'h34) begin n_err++; $display("FAIL bp_stall%0d got v=%b %h want v=1 34", i, byte_valid, byte_out); end
            n_vec++; if (word_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_pend%0d got %b want 0", i, word_ready); end
            if (i < 2) step();
        end
        byte_ready = 1'b1;
        step();
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'h12) begin n_err++; $display("FAIL bp_b1 got v=%b %h want v=1 12", byte_valid, byte_out); end
        n_vec++; if (word_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_second got %b want 0", word_ready); end
        step();
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'hEF) begin n_err++; $display("FAIL bp_pend_b0 got v=%b %h want v=1 ef", byte_valid, byte_out); end
        n_vec++; if (word_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_handoff got %b want 1", word_ready); end
        step();
        n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'hBE) begin n_err++; $display("FAIL bp_pend_b1 got v=%b %h want v=1 be", byte_valid, byte_out); end
        step();
        n_vec++; if (byte_valid !== 1'b0 || words_sent !== 8'd3) begin n_err++; $display("FAIL bp_end got v=%b count=%0d want v=0 count=3", byte_valid, words_sent); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [7:0]  exp_bytes [6];
        int          wi;
        words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506;
        exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h01; exp_bytes[2] = 8'h04;
        exp_bytes[3] = 8'h03; exp_bytes[4] = 8'h06; exp_bytes[5] = 8'h05;
        wi = 0;
        byte_ready = 1'b1;
        word_in    = words[0];
        word_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (word_valid && word_ready) wi++;
            step();
            word_valid = (wi < 3);
            word_in    = (wi < 3) ? words[wi] : 16'h0000;
            n_vec++; if (byte_valid !== 1'b1 || byte_out !== exp_bytes[c]) begin n_err++; $display("FAIL stream_b%0d got v=%b %h want v=1 %h", c, byte_valid, byte_out, exp_bytes[c]); end
        end
        word_valid = 1'b0;
        step();
        n_vec++; if (byte_valid !== 1'b0 || words_sent !== 8'd6) begin n_err++; $display("FAIL stream_end got v=%b count=%0d want v=0 count=6", byte_valid, words_sent); end
    endtask

    task automatic test_reset_mid();
        byte_ready = 1'b0;
        word_in    = 16'h1111;
        word_valid = 1'b1;
        step();
        word_in = 16'h2222;
        step();
        word_valid = 1'b0;
        byte_ready = 1'b1;
        step();
        byte_ready = 1'b0;
        n_vec++; if (byte_out !== 8'h11 || word_ready !== 1'b0) begin n_err++; $display("FAIL rmid_pre got %h ready=%b want 11 ready=0", byte_out, word_ready); end
        #2;
        NReset = 1'b0;
        #1;
        n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_valid got v=%b busy=%b want 0 0", byte_valid, busy); end
        n_vec++; if (words_sent !== 8'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", words_sent); end
        n_vec++; if (word_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b want 1", word_ready); end
        step();
        NReset     = 1'b1;
        byte_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++; if (byte_valid !== 1'b0 || word_ready !== 1'b1) begin n_err++; $display("FAIL rmid_stale%0d got v=%b ready=%b want 0 1", c, byte_valid, word_ready); end
        end
    endtask

    task automatic test_wrap_msb_first();
        int          wi;
        int          bi;
        int          cyc;
        logic [15:0] w;
        logic [7:0]  exp_b;
        wi = 0; bi = 0; cyc = 0;
        m_byte_ready = 1'b1;
        m_word_in    = 16'hCAFE;
        m_word_valid = 1'b1;
        while (bi < 512 && cyc < 2000) begin
            if (m_word_valid && m_word_ready) wi++;
            if (m_byte_valid) begin
                w     = (bi / 2 == 0) ? 16'hCAFE : {8'(bi / 2), ~8'(bi / 2)};
                exp_b = (bi % 2 == 0) ? w[15:8] : w[7:0];
                n_vec++; if (m_byte_out !== exp_b) begin n_err++; $display("FAIL wrap_byte%0d got %h want %h", bi, m_byte_out, exp_b); end
                bi++;
            end
            step();
            cyc++;
            m_word_valid = (wi < 256);
            m_word_in    = {8'(wi), ~8'(wi)};
            if (bi == 510) begin
                n_vec++; if (m_words_sent !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d want 255", m_words_sent); end
            end
        end
        m_word_valid = 1'b0;
        n_vec++; if (bi != 512) begin n_err++; $display("FAIL wrap_timeout got %0d bytes want 512", bi); end
        step();
        n_vec++; if (m_words_sent !== 8'd0 || m_byte_valid !== 1'b0) begin n_err++; $display("FAIL wrap_zero got count=%0d v=%b want 0 0", m_words_sent, m_byte_valid); end
    endtask

    task automatic test_round_trip();
        logic [15:0] sent_q [$];
        logic [15:0] exp_w;
        logic [7:0]  low_b;
        logic        half;
        logic        acc, xfr, prev_stall;
        logic [7:0]  prev_byte;
        int          n_acc, n_rx, cyc;
        n_acc = 0; n_rx = 0; cyc = 0; half = 1'b0; low_b = 8'h00;
        prev_stall = 1'b0; prev_byte = 8'h00;
        word_valid = 1'b0;
        byte_ready = 1'b0;
        while (n_rx < 40 && cyc < 3000) begin
            if (prev_stall) begin
                n_vec++; if (byte_valid !== 1'b1 || byte_out !== prev_byte) begin n_err++; $display("FAIL rt_stable got v=%b %h want v=1 %h", byte_valid, byte_out, prev_byte); end
            end
            word_valid = (n_acc < 40) && ($urandom_range(0, 3) != 0);
            word_in    = 16'($urandom);
            byte_ready = ($urandom_range(0, 2) != 0);
            acc = word_valid && word_ready;
            xfr = byte_valid && byte_ready;
            if (acc) begin sent_q.push_back(word_in); n_acc++; end
            if (xfr) begin
                if (!half) low_b = byte_out;
                else begin
                    exp_w = (sent_q.size() > 0) ? sent_q.pop_front() : 16'hxxxx;
                    n_vec++; if ({byte_out, low_b} !== exp_w) begin n_err++; $display("FAIL rt_word%0d got %h want %h", n_rx, {byte_out, low_b}, exp_w); end
                    n_rx++;
                end
                half = !half;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
            step();
            cyc++;
        end
        word_valid = 1'b0;
        n_vec++; if (n_rx != 40) begin n_err++; $display("FAIL rt_timeout got %0d words want 40", n_rx); end
    endtask

    initial begin
        NReset = 1'b0;
        word_in = 16'h0000; word_valid = 1'b0; byte_ready = 1'b0;
        m_word_in = 16'h0000; m_word_valid = 1'b0; m_byte_ready = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap_msb_first();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shiftreg16to8.md
Name: shiftreg16to8

Overview:
Word-to-byte serializer: accepts 16-bit words over a valid/ready handshake and emits each word as two 8-bit bytes over a second valid/ready handshake. It is the transmit-side counterpart of the team's 8-to-16 byte assembler. With LSB_FIRST=1, the low byte is sent first, so the assembler rebuilds the original word. A one-word pending buffer lets a continuous word stream produce back-to-back bytes with no bubbles.

Parameters:
LSB_FIRST, 1, 1: word[7:0] is sent first, then word[15:8]. 0: word[15:8] is sent first.
CNT_W, 8, width of the words_sent counter.

Ports:
clk2  input  1  system clock; all registers update on the rising edge.
NReset  input  1  asynchronous, active-low reset.
word_in  input  16  word to serialize; sampled on a word handshake.
word_valid  input  1  word_in is valid.
word_ready  output  1  block can accept a word this cycle.
byte_out  output  8  current byte.
byte_valid  output  1  byte_out is valid. Usable directly as the receiver's shift_enable.
byte_ready  input  1  downstream consumes byte_out this cycle.
busy  output  1  a word is in flight (state != IDLE).
words_sent  output  CNT_W  count of fully transmitted words; wraps modulo 2^CNT_W.

Behaviour:
- Registers:
  - hold_reg[15:0]: word currently being sent.
  - pend_reg[15:0] and pend_full: one-word pending buffer.
  - state: one of IDLE, FIRST, SECOND.
  - words_sent counter.
- Reset (asynchronous, immediate):
  - state=IDLE, pend_full=0, hold_reg=0, pend_reg=0, words_sent=0.
  - Therefore byte_valid=0, byte_out=0, busy=0, word_ready=1.
  - Reset mid-word drops the in-flight and pending words. No partial byte is issued after release.
- Handshakes:
  - Word accept (wacc) = word_valid & word_ready.
  - Byte transfer (bxfr) = byte_valid & byte_ready.
  - word_ready = !pend_full. It is a function of registers only, with no combinational path from byte_ready.
- Outputs per state:
  - byte_valid = 1 in FIRST and SECOND, 0 in IDLE.
  - FIRST: byte_out = LSB_FIRST ? hold[7:0] : hold[15:8].
  - SECOND: byte_out = the other half of hold_reg.
  - IDLE: byte_out holds its last value; this is don't-care for checking.
- Stability: while byte_valid=1 and byte_ready=0, byte_out and byte_valid must not change.
- Transitions:
  - IDLE: on wacc, hold_reg<=word_in and go to FIRST. Latency is 1: the first byte is valid the cycle after accept. pend_full is always 0 in IDLE.
  - FIRST: on wacc (pend empty), pend_reg<=word_in and pend_full<=1. On bxfr, go to SECOND. Both may happen in the same cycle.
  - SECOND with bxfr:
    - words_sent<=words_sent+1.
    - If pend_full: hold_reg<=pend_reg, pend_full<=0, go to FIRST.
    - Else if wacc: hold_reg<=word_in (bypass), go to FIRST; pend stays empty.
    - Else go to IDLE.
  - SECOND without bxfr: on wacc (pend empty), load pend_reg and set pend_full.
  - pend_full=1 forces word_ready=0, so no accept can collide with a full buffer.
- Throughput: a continuous word stream with byte_ready tied high produces 1 byte per cycle indefinitely.
- Counter: wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Invariant: a word is never lost or duplicated; bytes are emitted strictly in word-accept order.

Test Plan:
- Single word (LSB_FIRST=1, byte_ready=1): accept 16'hA55A at cycle 0 -> byte_valid=1 with 8'h5A at cycle 1, 8'hA5 at cycle 2, byte_valid=0 and busy=0 at cycle 3; words_sent=1.
- Backpressure: accept 16'h1234, hold byte_ready=0 for 3 cycles in FIRST -> byte_out stays 8'h34 with byte_valid=1; after byte_ready=1, 8'h12 follows. Meanwhile accept 16'hBEEF into pend -> word_ready=0 until hand-off; 8'hEF and 8'hBE follow.
- Streaming: words 16'h0102, 16'h0304, 16'h0506 offered continuously with byte_ready=1 -> bytes 02,01,04,03,06,05 on 6 consecutive cycles with no bubble; words_sent=3.
- Reset mid-operation: assert NReset=0 in SECOND with pend full -> byte_valid drops immediately, words_sent=0. After release, word_ready=1 and no stale bytes appear.
- Wrap and order: LSB_FIRST=0, send 256 words -> 16'hCAFE emits 8'hCA then 8'hFE; words_sent returns to 0 after the 256th word.
- Round trip: drive byte_out/byte_valid into the 8-to-16 assembler (shift_enable=bxfr) with random byte_ready stalls -> every reassembled word equals the sent word.
